ex_div_ctrl: RTL and testbench
==============================

// Module: ex_div_ctrl
// PURPOSE
//   Multi-cycle divide sequencer attached to the EX stage. Accepts a DIV/DIVU
//   request from EX, runs a radix-2 restoring division one bit per cycle,
//   stalls the pipeline while busy, and returns {remainder, quotient} for HI/LO.
//   Annul (pipeline flush) aborts an operation in flight.
// PARAMETERS
//   WIDTH  32  operand width; the result is 2*WIDTH bits wide
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        reset: synchronous, active-high
//   start_i     in   1        request from EX; held high until ready_o is seen
//   signed_i    in   1        1=DIV (two's complement), 0=DIVU; sampled with start
//   opdata1_i   in   WIDTH    dividend; sampled with start
//   opdata2_i   in   WIDTH    divisor; sampled with start
//   annul_i     in   1        flush: abort the current/pending operation
//   result_o    out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
//   ready_o     out  1        result_o valid
//   stallreq_o  out  1        pipeline stall request (combinational)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, result_o=0, ready_o=0. Same on any rst cycle,
//     including mid-operation; the operands are discarded.
//   FSM states: IDLE, DIVZERO, ON, END.
//   IDLE: start_i & !annul_i -> latch the operands, sign flags and signed_i.
//     Divisor==0 -> DIVZERO; else -> ON with cnt=0.
//     Signed mode: the datapath works on abs(operands), computed by two's negate.
//   DIVZERO: -> END next edge, result_o=0, ready_o=1.
//   ON: while cnt<WIDTH, do one restoring step per cycle and increment cnt:
//     partial = {rem,quo}<<1; if partial[2W-1:W] >= divisor then subtract and set
//     quotient bit=1.
//     At cnt==WIDTH, apply the sign fix and go to END with ready_o=1:
//     quotient is negated if the signs differ; remainder takes the dividend sign.
//     annul_i in ON -> IDLE on the next edge, ready_o stays 0, result_o unchanged.
//   END: result_o and ready_o are held stable while start_i=1.
//     start_i=0 -> IDLE, ready_o=0. annul_i in END -> IDLE, ready_o=0.
//   Latency: if start_i is sampled at edge T in IDLE, ready_o is first high
//     after edge T+WIDTH+2 (34 edges for WIDTH=32). Divide by zero: after edge T+2.
//   stallreq_o = start_i & !ready_o & !annul_i. The stall is high from the first
//     request cycle until the result cycle, with no bubble.
//   Overflow case: -2^(W-1) / -1 gives quotient 0x80000000 and remainder 0,
//     from natural wrap. There is no exception output.
//   annul_i has priority over start_i in every state. start_i & annul_i in
//     IDLE -> stay in IDLE.
//   Counter width is clog2(WIDTH+1). cnt never exceeds WIDTH.
//   A new start is accepted only from IDLE. There is no back-to-back issue
//     without start_i dropping for at least one cycle.
// TESTING
//   1. DIVU 100/7 -> result_o={0x00000002,0x0000000E}. ready_o first high 34
//      edges after start. stallreq_o high exactly until then.
//   2. DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 ->
//      quotient 0xFFFFFFFD, remainder 0x00000001.
//   3. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//      DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
//   4. Divisor 0 (any dividend) -> result_o=0. ready_o high 2 edges after the
//      start edge. No ON cycles.
//   5. annul_i pulsed 10 cycles into ON -> IDLE next edge, ready_o never rises.
//      A following DIVU 9/3 returns {0,3} with full latency.
//   6. rst asserted mid-ON -> all outputs 0, state IDLE. Holding start_i in END
//      keeps result_o stable for 5 cycles. Dropping start_i -> ready_o=0 on the
//      next edge.

Source files
------------

// File: rtl/ex_div_if.sv
// EX-stage divider request/response bundle: operands and flush in, result, ready and stall out.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for the EX stage.
// Returns {remainder, quotient}; stalls the pipeline while busy; annul aborts.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  ST_IDLE    | waiting for start_i; operands latched on acceptance
//  ST_DIVZERO | divisor was zero; result forced to 0
//  ST_ON      | one restoring step per cycle, sign fix when cnt==WIDTH
//  ST_END     | result held; ready_o asserted while start_i stays high
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div_if
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 start, annul, accept;
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     op1_abs, op2_abs;
    logic [WIDTH:0]       minuend, diff;
    logic                 take_sub;
    logic [WIDTH-1:0]     rem_step, quo_step;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 cnt_done;

    assign start  = div_if.start_i;
    assign annul  = div_if.annul_i;
    assign accept = start & ~annul;

    // Signed mode runs the core on magnitudes; the most negative value maps onto itself.
    assign op1_neg = div_if.signed_i & div_if.opdata1_i[WIDTH-1];
    assign op2_neg = div_if.signed_i & div_if.opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? ('0 - div_if.opdata1_i) : div_if.opdata1_i;
    assign op2_abs = op2_neg ? ('0 - div_if.opdata2_i) : div_if.opdata2_i;

    // Partial remainder kept one bit wider so divisors above 2^(WIDTH-1) never lose the carry-out.
    assign minuend  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = minuend - {1'b0, dvsr_q};
    assign take_sub = ~diff[WIDTH];
    assign rem_step = take_sub ? diff[WIDTH-1:0] : minuend[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], take_sub};

    assign quo_fix  = neg_quo_q ? ('0 - quo_q) : quo_q;
    assign rem_fix  = neg_rem_q ? ('0 - rem_q) : rem_q;
    assign cnt_done = (cnt_q == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (div_if.opdata2_i == '0) ? ST_DIVZERO : ST_ON;
                    end
                end
                ST_DIVZERO: state_d = ST_END;
                ST_ON: begin
                    if (cnt_done) begin
                        state_d = ST_END;
                    end
                end
                ST_END: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        // ready_o is only ever high in END; leaving END by any path clears it.
        ready_d   = (state_q == ST_END) & accept;
        if (!annul) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = op1_abs;
                        dvsr_d    = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
                ST_DIVZERO: result_d = '0;
                ST_ON: begin
                    if (!cnt_done) begin
                        rem_d = rem_step;
                        quo_d = quo_step;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        result_d = {rem_fix, quo_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.result_o   = result_q;
    assign div_if.ready_o    = ready_q;
    assign div_if.stallreq_o = start & ~ready_q & ~annul;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: latency-counting model checked every cycle plus literal vectors.
module tb_ex_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, sgn = 1'b0, annul = 1'b0;
    logic [W-1:0] op1 = '0, op2 = '0;
    logic [2*W-1:0] result_o;
    logic ready_o, stallreq_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_div_if #(.WIDTH(W)) dif ();
    assign dif.start_i   = start;
    assign dif.signed_i  = sgn;
    assign dif.opdata1_i = op1;
    assign dif.opdata2_i = op2;
    assign dif.annul_i   = annul;
    assign result_o   = dif.result_o;
    assign ready_o    = dif.ready_o;
    assign stallreq_o = dif.stallreq_o;

    ex_div_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .div_if(dif));

    function automatic logic [2*W-1:0] golden(logic sg, logic [W-1:0] a, logic [W-1:0] b);
        longint la, lb, q, r;
        if (b == '0) return '0;
        if (sg) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'b0, a});
            lb = longint'({32'b0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted request completes a fixed number of edges later.
    logic          m_init = 1'b0;
    logic          m_busy = 1'b0, m_ready = 1'b0, m_res_known = 1'b0;
    int            m_left = 0;
    logic [2*W-1:0] m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        m_init = 1'b1;
        if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_res = '0; m_res_known = 1'b1; m_left = 0;
        end else if (annul) begin
            m_busy = 1'b0; m_ready = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_ready = 1'b1; m_res = m_pend; m_res_known = 1'b1;
            end
        end else if (m_ready) begin
            if (!start) m_ready = 1'b0;
        end else if (start) begin
            m_pend = golden(sgn, op1, op2);
            m_left = (op2 == '0) ? 2 : W + 2;
            m_busy = 1'b1;
            m_res_known = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (m_init) begin
            check("ready", {63'b0, ready_o}, {63'b0, m_ready});
            check("stall", {63'b0, stallreq_o}, {63'b0, start & ~m_ready & ~annul});
            if (m_res_known) check("result", result_o, m_res);
        end
    end

    task automatic do_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int hold);
        int n;
        check("model_pin", golden(sg, a, b), {er, eq});
        @(negedge clk);
        start = 1'b1; sgn = sg; op1 = a; op2 = b;
        n = 0;
        #1;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
        end
        check("timeout", {63'b0, ready_o}, 64'd1);
        check("latency", 64'(n - 1), (b == '0) ? 64'd2 : 64'(W + 2));
        check("value", result_o, {er, eq});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold", result_o, {er, eq});
            check("hold_rdy", {63'b0, ready_o}, 64'd1);
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        check("drop", {63'b0, ready_o}, 64'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {63'b0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", {63'b0, stallreq_o}, 64'd0);
        rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 0);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0);
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h00000000, 0);
        do_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, 0);
        do_op(1'b1, 32'd12345, 32'd0, 32'h00000000, 32'h00000000, 0);
        do_op(1'b0, 32'h00000000, 32'd0, 32'h00000000, 32'h00000000, 0);

        // start together with annul in IDLE must not launch anything
        @(negedge clk);
        start = 1'b1; annul = 1'b1; sgn = 1'b0; op1 = 32'd50; op2 = 32'd5;
        repeat (3) @(negedge clk);
        #1;
        check("idle_annul_stall", {63'b0, stallreq_o}, 64'd0);
        start = 1'b0; annul = 1'b0;

        // annul 10 cycles into ON
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        do_op(1'b0, 32'd9, 32'd3, 32'h00000003, 32'h00000000, 0);

        do_op(1'b0, 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'h0000000F, 5);

        // synchronous reset mid-ON
        @(negedge clk);
        start = 1'b1; sgn = 1'b1; op1 = 32'd1000; op2 = 32'd7;
        repeat (15) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_ready", {63'b0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_stall", {63'b0, stallreq_o}, 64'd0);
        rst = 1'b0;
        do_op(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
